// File: rtl/inst_mem_loader_pkg.sv
// Shared controller definitions: instruction opcodes, field layout and loader FSM states.
// The decoder and the loader both import this so opcode values live in one place.
package inst_mem_loader_pkg;

  typedef enum logic [3:0] {
    OP_NOP            = 4'd0,
    OP_LDMEM          = 4'd1,
    OP_STMEM          = 4'd2,
    OP_RDBUF          = 4'd3,
    OP_WRBUF          = 4'd4,
    OP_GENADDR_HI     = 4'd5,
    OP_GENADDR_LO     = 4'd6,
    OP_LOOP           = 4'd7,
    OP_BLOCK_END      = 4'd8,
    OP_BASE_ADDR      = 4'd9,
    OP_PU_BLOCK_START = 4'd10,
    OP_COMPUTE_R      = 4'd11,
    OP_COMPUTE_I      = 4'd12
  } opcode_t;

  // Instruction word layout, MSB first: [31:28] [27:21] [20:16] [15:0]
  typedef struct packed {
    logic [3:0]  op_code;
    logic [6:0]  op_spec;
    logic [4:0]  loop_id;
    logic [15:0] immediate;
  } inst_fields_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PU_SKIP,
    ST_DONE
  } loader_state_t;

endpackage

// File: rtl/inst_mem_loader.sv
// Streams instruction words into imem, parsing opcodes on the fly so the load
// stops on the last-block marker, the requested word count, or a full memory.
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int unsigned IMEM_ADDR_W = 10,
  parameter int unsigned INST_W      = 32,
  parameter int unsigned OP_CODE_W   = 4,
  parameter int unsigned IMM_WIDTH   = 16,
  parameter int unsigned BLK_CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [IMEM_ADDR_W:0]   num_words,
  input  logic [INST_W-1:0]      s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic                   imem_write_req,
  output logic [IMEM_ADDR_W-1:0] imem_write_addr,
  output logic [INST_W-1:0]      imem_write_data,
  output logic                   done,
  output logic [IMEM_ADDR_W:0]   load_count,
  output logic [BLK_CNT_W-1:0]   block_count,
  output logic                   err_no_last,
  output logic                   err_overflow
);

  loader_state_t          state, state_next;
  logic [IMEM_ADDR_W-1:0] wr_ptr;
  logic [IMEM_ADDR_W:0]   num_words_q;
  logic [IMM_WIDTH-1:0]   skip_cnt;
  logic [OP_CODE_W-1:0]   op_code;
  logic [IMM_WIDTH-1:0]   immediate;
  logic                   accept;
  logic                   is_block_end, is_pu_start;
  logic                   term_last, term_count, term_full;

  assign op_code      = s_data[INST_W-1 -: OP_CODE_W];
  assign immediate    = s_data[IMM_WIDTH-1:0];
  assign accept       = s_valid && s_ready;
  assign is_block_end = (op_code == OP_CODE_W'(OP_BLOCK_END));
  assign is_pu_start  = (op_code == OP_CODE_W'(OP_PU_BLOCK_START));

  // Termination candidates for the word on the stream; only meaningful on accept.
  assign term_last  = (state == ST_LOAD) && is_block_end && immediate[0];
  assign term_count = ((load_count + (IMEM_ADDR_W+1)'(1)) == num_words_q);
  assign term_full  = &wr_ptr;

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (start) state_next = (num_words == '0) ? ST_DONE : ST_LOAD;
      end
      ST_LOAD: begin
        if (accept) begin
          if (term_last || term_count || term_full) state_next = ST_DONE;
          else if (is_pu_start)                     state_next = ST_PU_SKIP;
        end
      end
      ST_PU_SKIP: begin
        if (accept) begin
          if (term_count || term_full) state_next = ST_DONE;
          else if (skip_cnt == '0)     state_next = ST_LOAD;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    s_ready = 1'b0;
    done    = 1'b0;
    unique case (state)
      ST_LOAD, ST_PU_SKIP: s_ready = 1'b1;
      ST_DONE:             done    = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr          <= '0;
      num_words_q     <= '0;
      skip_cnt        <= '0;
      load_count      <= '0;
      block_count     <= '0;
      err_no_last     <= 1'b0;
      err_overflow    <= 1'b0;
      imem_write_req  <= 1'b0;
      imem_write_addr <= '0;
      imem_write_data <= '0;
    end else begin
      imem_write_req <= accept;
      if ((state == ST_IDLE) && start) begin
        wr_ptr       <= '0;
        num_words_q  <= num_words;
        load_count   <= '0;
        block_count  <= '0;
        err_overflow <= 1'b0;
        err_no_last  <= (num_words == '0);
      end
      if (accept) begin
        imem_write_addr <= wr_ptr;
        imem_write_data <= s_data;
        wr_ptr          <= wr_ptr + IMEM_ADDR_W'(1);
        load_count      <= load_count + (IMEM_ADDR_W+1)'(1);
        if ((state == ST_LOAD) && is_block_end && !(&block_count))
          block_count <= block_count + BLK_CNT_W'(1);
        // Count-reached outranks memory-full, so overflow only flags when count did not also hit.
        if (!term_last && (term_count || term_full))
          err_no_last <= 1'b1;
        if (!term_last && !term_count && term_full)
          err_overflow <= 1'b1;
        if ((state == ST_LOAD) && is_pu_start)
          skip_cnt <= immediate;
        else if (state == ST_PU_SKIP)
          skip_cnt <= skip_cnt - IMM_WIDTH'(1);
      end
    end
  end

endmodule
